dmem_arbiter: RTL

Single-port data-memory arbiter between the pipelined core's MEM stage and a debug/loader port. The core has priority every cycle. A pending debug request is guaranteed service after `MAX_WAIT` consecutive lost cycles: the arbiter steals the port and asserts `core_stall` for one cycle. It sits between the datapath's DM_* signals and `dmem`.

---
 rtl/dmem_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core MEM stage has priority, debug port is guaranteed a steal after MAX_WAIT lost cycles.
// Optional grant counters are enabled with the DMEM_ARB_STATS_EN macro.
module dmem_arbiter #(
  parameter int N        = 64,
  parameter int AW       = 6,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [N-1:0]  core_addr,
  input  logic [N-1:0]  core_wdata,
  output logic [N-1:0]  core_rdata,
  output logic          core_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [N-1:0]  dbg_wdata,
  output logic          dbg_ack,
  output logic [N-1:0]  dbg_rdata,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]   core_grants,
  output logic [31:0]   dbg_grants
`endif
);

  typedef enum logic {IDLE, ACK} state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       dbg_elig;
  logic       steal;
  logic       dbg_own;
  logic       core_own;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^{core_addr[N-1:AW+3], core_addr[2:0]};

  always_comb begin
    dbg_elig = dbg_req && (state == IDLE);
    steal    = dbg_elig && core_req && (wait_cnt >= 8'(MAX_WAIT));
    dbg_own  = dbg_elig && (!core_req || steal);
    core_own = core_req && !dbg_own;
  end

  // Gating with reset keeps the memory quiet while reset is held low.
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset && dbg_own) begin
      mem_we    = dbg_we;
      mem_re    = ~dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (reset && core_own) begin
      mem_we    = core_we;
      mem_re    = ~core_we;
      mem_addr  = core_addr[AW+2:3];
      mem_wdata = core_wdata;
    end
  end

  assign core_rdata = mem_rdata;
  assign core_stall = reset && steal;
  assign dbg_ack    = (state == ACK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      dbg_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (dbg_own) begin
          state <= ACK;
          if (!dbg_we) dbg_rdata <= mem_rdata;
        end
        ACK:  state <= IDLE;
        default: state <= IDLE;
      endcase
      // Counts only cycles where an eligible request lost the port to the core.
      if (!dbg_req || dbg_own)
        wait_cnt <= 8'd0;
      else if (dbg_elig && core_req && wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_grants <= 32'd0;
      dbg_grants  <= 32'd0;
    end else begin
      if (core_own) core_grants <= core_grants + 32'd1;
      if (dbg_own)  dbg_grants  <= dbg_grants + 32'd1;
    end
  end
`endif

endmodule
